// File: rtl/dna_pkg.sv
// Shared types and constants for the device-DNA reader.
// Holds the FSM state type, the standard ID widths and the counter width helper.
package dna_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } dna_state_e;

    localparam int unsigned DNA_WIDTH_7S = 57;
    localparam int unsigned DNA_WIDTH_US = 96;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/dna_port_model.sv
// Behavioural stand-in for the device-DNA shift primitive.
// READ loads a fixed ID and SHIFT rotates through DIN; DOUT is the register MSB.
module dna_port_model #(
    parameter int unsigned           DNA_WIDTH     = 57,
    parameter logic [DNA_WIDTH-1:0]  SIM_DNA_VALUE = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic read_i,
    input  logic shift_i,
    input  logic din_i,
    output logic dout_o
);

    logic [DNA_WIDTH-1:0] reg_q;

    // READ wins over SHIFT when both are asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else if (read_i) begin
            reg_q <= SIM_DNA_VALUE;
        end else if (shift_i) begin
            reg_q <= {reg_q[DNA_WIDTH-2:0], din_i};
        end
    end

    assign dout_o = reg_q[DNA_WIDTH-1];

endmodule

// File: rtl/dna_reader.sv
// Sequences a device-DNA primitive through READ then DNA_WIDTH SHIFTs and captures the ID.
// The ID is held with valid_o until the next start request.
module dna_reader
    import dna_pkg::*;
#(
    parameter int unsigned          DNA_WIDTH     = DNA_WIDTH_7S,
    parameter bit                   SIM_MODE      = 1'b0,
    parameter logic [DNA_WIDTH-1:0] SIM_DNA_VALUE = '0,
    parameter bit                   AUTO_START    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 dna_dout_i,
    output logic                 dna_read_o,
    output logic                 dna_shift_o,
    output logic                 dna_din_o,
    output logic [DNA_WIDTH-1:0] dna_o,
    output logic                 valid_o,
    output logic                 busy_o
);

    localparam int unsigned    CntW    = cnt_width(DNA_WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(DNA_WIDTH - 1);

    dna_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            auto_q;
    logic            dout;

    if (SIM_MODE) begin : g_model
        logic unused_dout;
        logic model_dout;

        assign unused_dout = dna_dout_i;

        dna_port_model #(
            .DNA_WIDTH     (DNA_WIDTH),
            .SIM_DNA_VALUE (SIM_DNA_VALUE)
        ) u_model (
            .clk     (clk),
            .rst_n   (rst_n),
            .read_i  (dna_read_o),
            .shift_i (dna_shift_o),
            .din_i   (dna_din_o),
            .dout_o  (model_dout)
        );

        assign dout = model_dout;
    end else begin : g_port
        assign dout = dna_dout_i;
    end

    // Feeding DOUT back to DIN rotates the primitive back to its loaded image
    assign dna_din_o = dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            auto_q      <= AUTO_START;
            dna_o       <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            dna_read_o  <= 1'b0;
            dna_shift_o <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i || auto_q) begin
                        state_q    <= StLoad;
                        auto_q     <= 1'b0;
                        cnt_q      <= '0;
                        dna_o      <= '0;
                        valid_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        dna_read_o <= 1'b1;
                    end
                end
                StLoad: begin
                    state_q     <= StShift;
                    cnt_q       <= '0;
                    dna_read_o  <= 1'b0;
                    dna_shift_o <= 1'b1;
                end
                StShift: begin
                    dna_o <= {dna_o[DNA_WIDTH-2:0], dout};
                    if (cnt_q == CntLast) begin
                        state_q     <= StDone;
                        dna_shift_o <= 1'b0;
                        busy_o      <= 1'b0;
                        valid_o     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
